// File: rtl/nco_io_pkg.sv
// Shared constants and sample-pair type for the NCO-to-terminal word path.
// Fixed chunking geometry: a 12-bit word leaves as six 2-bit chunks.
package nco_io_pkg;

  localparam int CHUNK_W = 2;
  localparam int NCHUNK  = 6;
  localparam int WORD_W  = 12;

  typedef struct packed {
    logic              is;
    logic [WORD_W-1:0] y;
    logic [WORD_W-1:0] x;
  } samp_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } xfer_state_t;

endpackage

// File: rtl/nco_sync_fifo.sv
// Single-clock FIFO with head-of-queue read data and an occupancy count.
// Push is ignored when full and pop is ignored when empty.
module nco_sync_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/nco_word_serializer.sv
// Buffers X/Y NCO sample pairs and, on each Rdy pulse, streams one pair to the
// output terminal as six 2-bit chunks, LSB first, with a held sign flag.
//
// state    | meaning
// ST_IDLE  | no transfer; Rdy starts a load (pop or reload of last pair)
// ST_SHIFT | chunks 0..5 on Xout/Yout; Rdy here is a protocol error
module nco_word_serializer
  import nco_io_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          samp_vld,
  input  logic [WORD_W-1:0]             samp_x,
  input  logic [WORD_W-1:0]             samp_y,
  input  logic                          samp_is,
  output logic                          samp_rdy,
  input  logic                          Rdy,
  output logic [CHUNK_W-1:0]            Xout,
  output logic [CHUNK_W-1:0]            Yout,
  output logic                          ISout,
  output logic                          busy,
  output logic                          underrun,
  output logic                          proto_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  xfer_state_t       state;
  xfer_state_t       state_nxt;
  logic [2:0]        cnt;
  logic [WORD_W-1:0] shx;
  logic [WORD_W-1:0] shy;
  logic [WORD_W-1:0] last_x;
  logic [WORD_W-1:0] last_y;
  logic              last_is;

  samp_t             head;
  samp_t             in_samp;
  logic              fifo_full;
  logic              fifo_empty;
  logic              load;
  logic              last_chunk;

  assign in_samp = '{is: samp_is, y: samp_y, x: samp_x};

  nco_sync_fifo #(
    .WIDTH ($bits(samp_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (samp_vld & samp_rdy),
    .pop   (load & ~fifo_empty),
    .wdata (in_samp),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign samp_rdy   = ~fifo_full;
  assign busy       = (state == ST_SHIFT);
  assign load       = (state == ST_IDLE) & Rdy;
  assign last_chunk = (state == ST_SHIFT) & (cnt == 3'(NCHUNK-1));
  assign Xout       = shx[CHUNK_W-1:0];
  assign Yout       = shy[CHUNK_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (Rdy)        state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_chunk) state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      shx       <= '0;
      shy       <= '0;
      ISout     <= 1'b0;
      last_x    <= '0;
      last_y    <= '0;
      last_is   <= 1'b0;
      underrun  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (load) begin
        cnt <= '0;
        if (!fifo_empty) begin
          shx     <= head.x;
          shy     <= head.y;
          ISout   <= head.is;
          last_x  <= head.x;
          last_y  <= head.y;
          last_is <= head.is;
        end else begin
          // Starved: repeat the previous pair so the terminal still sees a valid word.
          shx      <= last_x;
          shy      <= last_y;
          ISout    <= last_is;
          underrun <= 1'b1;
        end
      end else if (state == ST_SHIFT) begin
        if (last_chunk) begin
          cnt <= '0;
          shx <= '0;
          shy <= '0;
        end else begin
          cnt <= cnt + 3'd1;
          shx <= shx >> CHUNK_W;
          shy <= shy >> CHUNK_W;
        end
      end
      if (Rdy && state == ST_SHIFT) proto_err <= 1'b1;
    end
  end

endmodule
